z80_irq_ctrl: RTL and testbench
===============================

Z80_IRQ_CTRL -- requirements
Module: z80_irq_ctrl

Interface
REQ-001 SHALL provide parameter RESET_MASK, default 4'h0, the reset value of the mask register.
REQ-002 SHALL provide parameter RESET_BASE, default 8'h00, the reset value of the vector base register.
REQ-003 SHALL have port clk  input  1  system clock; the only clock.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port cs  input  1  register select (IO decode 20-23).
REQ-006 SHALL have port we  input  1  write enable (~wr_n).
REQ-007 SHALL have port addr  input  2  register index.
REQ-008 SHALL have port din  input  8  CPU write data.
REQ-009 SHALL have port dout  output  8  register read data, combinational from addr.
REQ-010 SHALL have port irq_in  input  4  level request lines; bit 0 highest priority.
REQ-011 SHALL have port m1_n  input  1  CPU M1, active low.
REQ-012 SHALL have port iorq_n  input  1  CPU IORQ, active low.
REQ-013 SHALL have port int_n  output  1  CPU interrupt request, active low, registered.
REQ-014 SHALL have port vec_oe  output  1  high while the vector is to be muxed onto di.
REQ-015 SHALL have port vec  output  8  IM2 vector.

Function
REQ-016 SHALL latch a pending bit on each irq_in rising edge (0->1 vs previous-cycle sample); edge to pending = 1 cycle.
REQ-017 SHALL implement registers: 0 pending (read; write-1-to-clear), 1 mask (r/w, 1 = enabled), 2 vector base (r/w), 3 in-service (read; any write = EOI).
REQ-018 SHALL, for unmapped bits, read 0 in dout[7:4] of registers 0, 1 and 3.
REQ-019 SHALL compute eligible = pending & mask, restricted to sources of strictly higher priority than the highest in-service bit (all sources when in-service = 0).
REQ-020 SHALL use FSM IDLE -> REQ -> ACK -> IDLE.
- IDLE: int_n=1; goes to REQ when eligible != 0.
- REQ: int_n=0; goes to ACK on the first cycle m1_n=0 and iorq_n=0; returns to IDLE if eligible falls to 0 first.
REQ-021 SHALL, on the REQ->ACK edge, latch id = lowest-index eligible bit, clear pending[id], set inservice[id], and drive int_n=1.
REQ-022 SHALL, in ACK, hold vec_oe=1 with vec = {base[7:3], id[1:0], 1'b0}, returning to IDLE (vec_oe=0) on the first cycle iorq_n=1.
REQ-023 SHALL drive vec_oe=0 and vec=8'h00 outside ACK.
REQ-024 SHALL clear the lowest-index set in-service bit on an EOI write; EOI with in-service = 0 is a no-op.
REQ-025 SHALL give a new edge priority over a write-1-to-clear of the same pending bit in the same cycle (bit stays 1).
REQ-026 SHALL let a mask or base write during ACK take effect for later acknowledges only; latched id and vec stay stable.
REQ-027 SHALL allow nesting: a higher-priority source may reach REQ while a lower one is in service.

Reset
REQ-028 SHALL, on reset (any state, including mid-ACK), set pending=0, inservice=0, mask=RESET_MASK, base=RESET_BASE, edge history=0, FSM=IDLE, int_n=1, vec_oe=0, vec=8'h00.
REQ-029 SHALL NOT record an edge from an irq_in already high when reset releases.

Verification
REQ-030 SHALL cover basic ack: mask=4'hF, base=8'h80, pulse irq_in[2] -> int_n=0 within 2 cycles; M1+IORQ low -> vec_oe=1, vec=8'h84, int_n=1; inservice reads 4'h4.
REQ-031 SHALL cover priority: irq_in[3] and irq_in[1] in the same cycle -> vec=8'h82 first; after EOI -> second ack vec=8'h86.
REQ-032 SHALL cover masking and nesting: mask=4'h2 with irq_in[0] edge -> int_n stays 1, pending=4'h1; with inservice=4'h4, irq_in[3] edge -> no request and irq_in[0] (mask=4'hF) -> request.
REQ-033 SHALL cover clear-vs-set collision: write 8'h02 to reg 0 in the same cycle as an irq_in[1] edge -> pending[1] reads 1.
REQ-034 SHALL cover reset mid-ACK: assert reset while vec_oe=1 -> next cycle vec_oe=0, int_n=1, all registers at reset values.

Source files
------------

// File: rtl/z80_irq_ctrl.sv
// z80_irq_ctrl -- four-source IM2 interrupt controller for a Z80 bus.
//
// Edges on irq_in latch pending bits. Enabled pending sources that outrank
// everything currently in service raise int_n. On the M1+IORQ acknowledge
// cycle the winning source moves to in-service, and its vector is driven
// until IORQ is released. The CPU retires the top in-service level with an
// EOI write.
//
// Ports
//   clk        system clock (only clock)
//   reset      synchronous, active-high reset
//   cs, we     register select / write enable from the IO decode
//   addr[1:0]  register index:
//                0 pending (W1C), 1 mask, 2 vector base, 3 in-service (write = EOI)
//   din[7:0]   write data
//   dout[7:0]  combinational read data for addr
//   irq_in[3:0] level request lines, bit 0 highest priority
//   m1_n, iorq_n CPU bus strobes, active low
//   int_n      registered interrupt request to the CPU, active low
//   vec_oe     high while vec must be muxed onto the CPU data bus
//   vec[7:0]   IM2 vector {base[7:3], id[1:0], 1'b0}
module z80_irq_ctrl #(
  parameter logic [3:0] RESET_MASK = 4'h0,
  parameter logic [7:0] RESET_BASE = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs,
  input  logic       we,
  input  logic [1:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic [3:0] irq_in,
  input  logic       m1_n,
  input  logic       iorq_n,
  output logic       int_n,
  output logic       vec_oe,
  output logic [7:0] vec
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t     r_state;
  logic [3:0] r_pending;
  logic [3:0] r_mask;
  logic [7:0] r_base;
  logic [3:0] r_inservice;
  logic [3:0] r_irq_prev;
  logic       r_armed;
  logic       r_int_n;
  logic       r_vec_oe;
  logic [7:0] r_vec;

  logic       w_wr;
  logic [3:0] w_rise;
  logic [3:0] w_allow;
  logic [3:0] w_elig;
  logic [1:0] w_id;
  logic       w_ack;
  logic [3:0] w_ack_oh;
  logic [3:0] w_w1c;
  logic [3:0] w_eoi_clr;

  // Edge detect, priority filtering and the per-cycle register update terms.
  always_comb begin
    logic blocked;
    w_wr = cs & we;
    // r_armed stays low for the first cycle after reset so a line that is
    // already high at reset release does not register as an edge.
    w_rise = r_armed ? (irq_in & ~r_irq_prev) : 4'h0;
    // A source is allowed only when no in-service bit of equal or higher
    // priority (lower or equal index) is set.
    blocked = 1'b0;
    for (int k = 0; k < 4; k++) begin
      blocked    = blocked | r_inservice[k];
      w_allow[k] = ~blocked;
    end
    w_elig = r_pending & r_mask & w_allow;
    w_id   = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (w_elig[k]) begin
        w_id = 2'(k);
      end else begin
        w_id = w_id;
      end
    end
    w_ack    = (r_state == ST_REQ) & ~m1_n & ~iorq_n & (|w_elig);
    w_ack_oh = w_ack ? (4'b0001 << w_id) : 4'h0;
    w_w1c    = (w_wr && (addr == 2'd0)) ? din[3:0] : 4'h0;
    // Lowest set bit of in-service, isolated with the two's-complement trick.
    w_eoi_clr = (w_wr && (addr == 2'd3)) ? (r_inservice & (~r_inservice + 4'd1)) : 4'h0;
  end

  // Register file, pending/in-service bookkeeping and edge history.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending   <= 4'h0;
      r_inservice <= 4'h0;
      r_mask      <= RESET_MASK;
      r_base      <= RESET_BASE;
      r_irq_prev  <= 4'h0;
      r_armed     <= 1'b0;
    end else begin
      // A fresh edge wins over both W1C and the acknowledge clear.
      r_pending   <= (r_pending & ~w_w1c & ~w_ack_oh) | w_rise;
      r_inservice <= (r_inservice & ~w_eoi_clr) | w_ack_oh;
      r_irq_prev  <= irq_in;
      r_armed     <= 1'b1;
      if (w_wr && (addr == 2'd1)) begin
        r_mask <= din[3:0];
      end else begin
        r_mask <= r_mask;
      end
      if (w_wr && (addr == 2'd2)) begin
        r_base <= din;
      end else begin
        r_base <= r_base;
      end
    end
  end

  // Request/acknowledge FSM with registered bus outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_int_n  <= 1'b1;
      r_vec_oe <= 1'b0;
      r_vec    <= 8'h00;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|w_elig) begin
            r_state <= ST_REQ;
            r_int_n <= 1'b0;
          end else begin
            r_int_n <= 1'b1;
          end
        end
        ST_REQ: begin
          if (!(|w_elig)) begin
            r_state <= ST_IDLE;
            r_int_n <= 1'b1;
          end else if (w_ack) begin
            // Vector is captured here, so later base writes cannot disturb it.
            r_state  <= ST_ACK;
            r_int_n  <= 1'b1;
            r_vec_oe <= 1'b1;
            r_vec    <= {r_base[7:3], w_id, 1'b0};
          end else begin
            r_int_n <= 1'b0;
          end
        end
        ST_ACK: begin
          if (iorq_n) begin
            r_state  <= ST_IDLE;
            r_vec_oe <= 1'b0;
            r_vec    <= 8'h00;
          end else begin
            r_vec_oe <= 1'b1;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_int_n  <= 1'b1;
          r_vec_oe <= 1'b0;
          r_vec    <= 8'h00;
        end
      endcase
    end
  end

  // Read mux; unmapped high nibbles read as zero.
  always_comb begin
    case (addr)
      2'd0:    dout = {4'h0, r_pending};
      2'd1:    dout = {4'h0, r_mask};
      2'd2:    dout = r_base;
      2'd3:    dout = {4'h0, r_inservice};
      default: dout = 8'h00;
    endcase
  end

  assign int_n  = r_int_n;
  assign vec_oe = r_vec_oe;
  assign vec    = r_vec;

endmodule

// File: tb/tb_z80_irq_ctrl.sv
// Scoreboard bench for z80_irq_ctrl: every cycle the stimulus side advances a
// behavioural model and queues the outputs expected after the next clock edge;
// an independent monitor pops and compares them against the DUT.
module tb_z80_irq_ctrl;

  logic       clk = 1'b0;
  logic       t_reset = 1'b1;
  logic       t_cs = 1'b0;
  logic       t_we = 1'b0;
  logic [1:0] t_addr = 2'd0;
  logic [7:0] t_din = 8'h00;
  logic [3:0] t_irq = 4'h0;
  logic       t_m1_n = 1'b1;
  logic       t_iorq_n = 1'b1;
  logic [7:0] dout;
  logic       int_n;
  logic       vec_oe;
  logic [7:0] vec;

  int checks = 0;
  int errors = 0;

  z80_irq_ctrl dut (
    .clk    (clk),
    .reset  (t_reset),
    .cs     (t_cs),
    .we     (t_we),
    .addr   (t_addr),
    .din    (t_din),
    .dout   (dout),
    .irq_in (t_irq),
    .m1_n   (t_m1_n),
    .iorq_n (t_iorq_n),
    .int_n  (int_n),
    .vec_oe (vec_oe),
    .vec    (vec)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       int_n;
    logic       vec_oe;
    logic [7:0] vec;
    logic [7:0] dout;
    int         tag;
  } exp_t;

  exp_t exp_q[$];

  // ---------------- behavioural model ----------------
  bit m_pend[4];
  bit m_mask[4];
  bit m_ins[4];
  bit m_prev[4];
  int m_base;
  bit m_armed;
  bit m_requesting;
  bit m_acking;
  int e_int_n;
  int e_vec_oe;
  int e_vec;
  int tag_cnt = 0;

  function automatic int bits_to_int(bit b0, bit b1, bit b2, bit b3);
    return int'(b0) + 2 * int'(b1) + 4 * int'(b2) + 8 * int'(b3);
  endfunction

  task automatic model_step();
    bit np[4];
    bit ni[4];
    int lim;
    int first;
    int lowest_ins;
    exp_t e;
    if (t_reset) begin
      for (int k = 0; k < 4; k++) begin
        m_pend[k] = 1'b0; m_mask[k] = 1'b0; m_ins[k] = 1'b0; m_prev[k] = 1'b0;
      end
      m_base = 0; m_armed = 1'b0; m_requesting = 1'b0; m_acking = 1'b0;
      e_int_n = 1; e_vec_oe = 0; e_vec = 0;
    end else begin
      // Highest in-service level limits which sources may interrupt.
      lim = 4;
      for (int k = 3; k >= 0; k--) if (m_ins[k]) lim = k;
      first = -1;
      for (int k = 3; k >= 0; k--) if (k < lim && m_pend[k] && m_mask[k]) first = k;
      lowest_ins = lim;
      for (int k = 0; k < 4; k++) begin
        np[k] = m_pend[k];
        ni[k] = m_ins[k];
      end
      if (m_acking) begin
        if (t_iorq_n) begin
          m_acking = 1'b0; e_vec_oe = 0; e_vec = 0;
        end
      end else if (m_requesting) begin
        if (first < 0) begin
          m_requesting = 1'b0; e_int_n = 1;
        end else if (!t_m1_n && !t_iorq_n) begin
          m_requesting = 1'b0; m_acking = 1'b1;
          e_int_n = 1; e_vec_oe = 1;
          e_vec = (m_base & 248) + first * 2;
          np[first] = 1'b0;
          ni[first] = 1'b1;
        end
      end else if (first >= 0) begin
        m_requesting = 1'b1; e_int_n = 0;
      end
      if (t_cs && t_we) begin
        case (t_addr)
          2'd0: for (int k = 0; k < 4; k++) if (t_din[k]) np[k] = 1'b0;
          2'd1: for (int k = 0; k < 4; k++) m_mask[k] = t_din[k];
          2'd2: m_base = int'(t_din);
          default: if (lowest_ins < 4) ni[lowest_ins] = 1'b0;
        endcase
      end
      for (int k = 0; k < 4; k++) begin
        if (m_armed && t_irq[k] && !m_prev[k]) np[k] = 1'b1;
        m_prev[k] = t_irq[k];
        m_pend[k] = np[k];
        m_ins[k]  = ni[k];
      end
      m_armed = 1'b1;
    end
    e.int_n  = logic'(e_int_n != 0);
    e.vec_oe = logic'(e_vec_oe != 0);
    e.vec    = 8'(e_vec);
    case (t_addr)
      2'd0: e.dout = 8'(bits_to_int(m_pend[0], m_pend[1], m_pend[2], m_pend[3]));
      2'd1: e.dout = 8'(bits_to_int(m_mask[0], m_mask[1], m_mask[2], m_mask[3]));
      2'd2: e.dout = 8'(m_base);
      default: e.dout = 8'(bits_to_int(m_ins[0], m_ins[1], m_ins[2], m_ins[3]));
    endcase
    tag_cnt++;
    e.tag = tag_cnt;
    exp_q.push_back(e);
  endtask

  // Inputs are already set: record expectation, then let one clock edge pass.
  task automatic tick();
    model_step();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    t_cs = 1'b1; t_we = 1'b1; t_addr = a; t_din = d;
    tick();
    t_cs = 1'b0; t_we = 1'b0;
  endtask

  task automatic cpu_ack();
    t_m1_n = 1'b0; t_iorq_n = 1'b0;
    tick();
    tick();
    t_m1_n = 1'b1; t_iorq_n = 1'b1;
    tick();
  endtask

  task automatic do_reset();
    t_reset = 1'b1;
    tick();
    t_reset = 1'b0;
  endtask

  // Monitor: compare each registered output set after every clock edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks += 4;
        if (int_n !== e.int_n) begin
          errors++;
          $display("FAIL int_n step %0d got %b exp %b", e.tag, int_n, e.int_n);
        end
        if (vec_oe !== e.vec_oe) begin
          errors++;
          $display("FAIL vec_oe step %0d got %b exp %b", e.tag, vec_oe, e.vec_oe);
        end
        if (vec !== e.vec) begin
          errors++;
          $display("FAIL vec step %0d got %h exp %h", e.tag, vec, e.vec);
        end
        if (dout !== e.dout) begin
          errors++;
          $display("FAIL dout step %0d addr %0d got %h exp %h", e.tag, t_addr, dout, e.dout);
        end
      end
    end
  end

  // Stimulus: directed scenarios, then randomized traffic.
  initial begin
    int ack_left;
    do_reset();
    t_addr = 2'd3;
    idle(2);

    // Basic acknowledge: vector 8'h84, in-service reads 4'h4.
    wr(2'd1, 8'h0F);
    wr(2'd2, 8'h80);
    t_irq = 4'b0100;
    idle(3);
    t_irq = 4'b0000;
    cpu_ack();
    t_addr = 2'd3;
    idle(2);
    wr(2'd3, 8'h00);

    // Priority: sources 3 and 1 together -> 8'h82 first, then 8'h86.
    t_irq = 4'b1010;
    idle(3);
    cpu_ack();
    t_addr = 2'd0;
    wr(2'd3, 8'h00);
    idle(2);
    cpu_ack();
    wr(2'd3, 8'h00);
    t_irq = 4'b0000;
    idle(1);

    // Masking: source 0 masked stays pending without a request.
    wr(2'd1, 8'h02);
    t_irq = 4'b0001;
    t_addr = 2'd0;
    idle(3);
    t_irq = 4'b0000;
    wr(2'd1, 8'h0F);
    cpu_ack();
    wr(2'd3, 8'h00);
    // Nesting: source 2 in service, source 3 blocked, source 0 interrupts.
    t_irq = 4'b0100;
    idle(3);
    cpu_ack();
    t_irq = 4'b1000;
    idle(3);
    t_irq = 4'b1001;
    idle(3);
    cpu_ack();
    t_addr = 2'd3;
    idle(1);
    wr(2'd3, 8'h00);
    wr(2'd3, 8'h00);
    idle(2);
    cpu_ack();
    wr(2'd3, 8'h00);
    wr(2'd3, 8'h00);
    t_irq = 4'b0000;
    idle(1);

    // Clear-vs-set collision on pending[1].
    wr(2'd1, 8'h00);
    t_irq = 4'b0010;
    wr(2'd0, 8'h02);
    t_addr = 2'd0;
    idle(2);
    wr(2'd0, 8'h0F);
    t_irq = 4'b0000;

    // Base write during ACK must not disturb the latched vector.
    wr(2'd1, 8'h0F);
    t_irq = 4'b0100;
    idle(3);
    t_m1_n = 1'b0; t_iorq_n = 1'b0;
    tick();
    t_m1_n = 1'b1;
    wr(2'd2, 8'hF8);
    tick();
    t_iorq_n = 1'b1;
    tick();
    wr(2'd3, 8'h00);
    t_irq = 4'b0000;

    // Reset while the vector is on the bus; lines held high across release.
    t_irq = 4'b0010;
    idle(3);
    t_m1_n = 1'b0; t_iorq_n = 1'b0;
    tick();
    tick();
    t_irq = 4'b1111;
    do_reset();
    t_m1_n = 1'b1; t_iorq_n = 1'b1;
    for (int a = 0; a < 4; a++) begin
      t_addr = 2'(a);
      tick();
    end
    wr(2'd1, 8'h0F);
    t_addr = 2'd0;
    idle(3);
    t_irq = 4'b0000;
    idle(2);

    // Randomized traffic with a loosely behaved CPU.
    ack_left = 0;
    for (int i = 0; i < 4000; i++) begin
      t_reset = ($urandom_range(0, 499) == 0);
      for (int k = 0; k < 4; k++)
        if ($urandom_range(0, 7) == 0) t_irq[k] = ~t_irq[k];
      t_addr = 2'($urandom_range(0, 3));
      t_din  = 8'($urandom);
      t_cs   = ($urandom_range(0, 4) == 0);
      t_we   = t_cs & ($urandom_range(0, 3) != 0);
      if (ack_left > 0) begin
        ack_left--;
        t_m1_n = 1'b0; t_iorq_n = 1'b0;
      end else if (e_int_n == 0 && $urandom_range(0, 2) == 0) begin
        ack_left = $urandom_range(0, 2);
        t_m1_n = 1'b0; t_iorq_n = 1'b0;
      end else begin
        t_m1_n = ($urandom_range(0, 9) != 0);
        t_iorq_n = ($urandom_range(0, 9) != 0);
      end
      tick();
    end
    t_reset = 1'b0; t_cs = 1'b0; t_we = 1'b0;
    t_m1_n = 1'b1; t_iorq_n = 1'b1;
    idle(2);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d entries exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
